id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 5-stage ARM pipeline; consumes PC+4 and instruction from the IF/ID register.
//  Holds the 16x32 register file (written by WB), decodes opcode and condition, and detects RAW hazards against EX/MEM.
//  Registers all decoded fields into the ID/EX pipeline register. Its hazard output drives the IF stage freeze.
// PARAMETERS
//  WIDTH     32  datapath / register width
//  NREGS     16  architectural registers (R0..R15), index width 4
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-low reset
//  flush          in   1   branch taken in EX; squash instruction entering ID/EX
//  pc_in          in   32  PC+4 from IF/ID register
//  instr_in       in   32  instruction from IF/ID register
//  status_nzcv    in   4   status register flags {N,Z,C,V}
//  wb_en_wb       in   1   write-back enable from WB stage
//  wb_dest        in   4   write-back register index
//  wb_value       in   32  write-back data
//  ex_dest/ex_wb_en    in  4/1  destination and wb enable of instruction in EX
//  mem_dest/mem_wb_en  in  4/1  destination and wb enable of instruction in MEM
//  hazard         out  1   combinational; 1 = freeze IF and IF/ID this cycle
//  pc_out         out  32  registered PC+4
//  val_rn, val_rm out  32  registered operand values
//  shift_operand  out  12  registered instr[11:0]
//  imm            out  1   registered I bit instr[25]
//  signed_imm_24  out  24  registered instr[23:0]
//  dest           out  4   registered Rd instr[15:12]
//  exe_cmd        out  4   registered ALU command
//  mem_r, mem_w, wb_en, b, s  out 1 each  registered control
// BEHAVIOUR
//  Reset (rst=0, async): all outputs and every register-file entry -> 0; hazard follows comb inputs.
//  Register file: write on posedge clk when wb_en_wb; read is combinational with write-through bypass
//    (reading wb_dest while wb_en_wb=1 returns wb_value same cycle).
//  Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
//  Mode 00 data-proc opcode->exe_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011,
//    SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000,
//    CMP 1010->0100 (wb_en=0), TST 1000->0110 (wb_en=0); others: wb_en=0, exe_cmd=0000.
//  Mode 01 memory: exe_cmd=0010; S=1 LDR (mem_r=1, wb_en=1); S=0 STR (mem_w=1, wb_en=0); s output forced 0.
//  Mode 10 branch: b=1, all other control 0. Mode 11: treated as no-op (all control 0).
//  Condition: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z,
//    GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1110 true, 1111 false.
//  Sources: src1=Rn, used unless MOV/MVN/branch; src2 = Rm when mode 00 & I=0, = Rd when STR, else unused.
//  hazard = (used src == ex_dest & ex_wb_en) | (used src == mem_dest & mem_wb_en); R15 treated like any other.
//  ID/EX register on posedge clk, priority: flush > hazard > condition-false > normal load.
//    flush, hazard or cond false: control (mem_r,mem_w,wb_en,b,s) <- 0 (bubble); data fields may load.
//    normal: all outputs <- decoded values, 1-cycle latency instr_in -> outputs.
//  Simultaneous flush & hazard: bubble; hazard still asserted (IF freeze is EX's concern).
//  Reset mid-operation clears pipeline register and regfile immediately regardless of clk.
// TESTING
//  T1 reset: rst=0 with instr_in=E3A00014 toggling clk -> all outputs 0; release, R0..R15 read 0.
//  T2 MOV R0,#20 (E3A00014) -> next cycle exe_cmd=0001, imm=1, dest=0, wb_en=1, shift_operand=014.
//  T3 WB writes R0=20 while ADD R1,R0,R0 (E0801000) in ID -> val_rn=val_rm=20 (bypass), exe_cmd=0010.
//  T4 ADD R1,R0,R0 with ex_dest=0, ex_wb_en=1 -> hazard=1, next cycle wb_en=0; ex_wb_en=0 -> hazard=0.
//  T5 ADDEQ (00801000) with nzcv=0000 -> bubble; with nzcv=0100 -> wb_en=1; cond 1111 -> bubble.
//  T6 flush=1 with LDR R2,[R1] (E5912000) -> mem_r=0, wb_en=0; flush=0 -> mem_r=1, wb_en=1, exe_cmd=0010.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, opcode/condition decode,
// RAW hazard detection against EX/MEM, and the ID/EX pipeline register.
module id_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic [3:0]       status_nzcv,
  input  logic             wb_en_wb,
  input  logic [3:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_value,
  input  logic [3:0]       ex_dest,
  input  logic             ex_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard,
  output logic [31:0]      pc_out,
  output logic [WIDTH-1:0] val_rn,
  output logic [WIDTH-1:0] val_rm,
  output logic [11:0]      shift_operand,
  output logic             imm,
  output logic [23:0]      signed_imm_24,
  output logic [3:0]       dest,
  output logic [3:0]       exe_cmd,
  output logic             mem_r,
  output logic             mem_w,
  output logic             wb_en,
  output logic             b,
  output logic             s
);

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  logic [WIDTH-1:0] rf [NREGS];

  logic [3:0] cond, opcode, rn, rd, rm, src2;
  mode_e      mode;
  logic       i_bit, s_bit;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_ok;
  logic       src1_used, src2_used;
  logic [3:0] d_cmd;
  logic       d_mr, d_mw, d_wb, d_b, d_s;
  logic [WIDTH-1:0] rn_val, rm_val;

  assign cond   = instr_in[31:28];
  assign mode   = mode_e'(instr_in[27:26]);
  assign i_bit  = instr_in[25];
  assign opcode = instr_in[24:21];
  assign s_bit  = instr_in[20];
  assign rn     = instr_in[19:16];
  assign rd     = instr_in[15:12];
  assign rm     = instr_in[3:0];
  assign {n_f, z_f, c_f, v_f} = status_nzcv;

  // Register file write port; reset clears every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en_wb) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // Second operand index is Rd for stores (value to store), otherwise Rm
  assign src2   = (mode == MODE_MEM && !s_bit) ? rd : rm;
  assign rn_val = (wb_en_wb && wb_dest == rn)   ? wb_value : rf[rn];
  assign rm_val = (wb_en_wb && wb_dest == src2) ? wb_value : rf[src2];

  // Condition code evaluation against current flags
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Opcode decode into ALU command, control bits and source usage
  always_comb begin
    d_cmd     = '0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_wb      = 1'b0;
    d_b       = 1'b0;
    d_s       = 1'b0;
    src1_used = 1'b1;
    src2_used = 1'b0;
    case (mode)
      MODE_DP: begin
        d_s       = s_bit;
        d_wb      = 1'b1;
        src2_used = !i_bit;
        case (opcode)
          4'b1101: begin d_cmd = 4'b0001; src1_used = 1'b0; end
          4'b1111: begin d_cmd = 4'b1001; src1_used = 1'b0; end
          4'b0100: d_cmd = 4'b0010;
          4'b0101: d_cmd = 4'b0011;
          4'b0010: d_cmd = 4'b0100;
          4'b0110: d_cmd = 4'b0101;
          4'b0000: d_cmd = 4'b0110;
          4'b1100: d_cmd = 4'b0111;
          4'b0001: d_cmd = 4'b1000;
          4'b1010: begin d_cmd = 4'b0100; d_wb = 1'b0; end
          4'b1000: begin d_cmd = 4'b0110; d_wb = 1'b0; end
          default: d_wb = 1'b0;
        endcase
      end
      MODE_MEM: begin
        d_cmd = 4'b0010;
        if (s_bit) begin
          d_mr = 1'b1;
          d_wb = 1'b1;
        end else begin
          d_mw      = 1'b1;
          src2_used = 1'b1;
        end
      end
      MODE_BR: begin
        d_b       = 1'b1;
        src1_used = 1'b0;
      end
      default: ;
    endcase
  end

  // RAW hazard: any used source matches a pending EX or MEM write
  assign hazard = (src1_used && ((ex_wb_en  && ex_dest  == rn) ||
                                 (mem_wb_en && mem_dest == rn))) ||
                  (src2_used && ((ex_wb_en  && ex_dest  == src2) ||
                                 (mem_wb_en && mem_dest == src2)));

  // ID/EX register; flush, hazard or failed condition inserts a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out        <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      shift_operand <= '0;
      imm           <= 1'b0;
      signed_imm_24 <= '0;
      dest          <= '0;
      exe_cmd       <= '0;
      mem_r         <= 1'b0;
      mem_w         <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
    end else begin
      pc_out        <= pc_in;
      val_rn        <= rn_val;
      val_rm        <= rm_val;
      shift_operand <= instr_in[11:0];
      imm           <= i_bit;
      signed_imm_24 <= instr_in[23:0];
      dest          <= rd;
      exe_cmd       <= d_cmd;
      if (flush || hazard || !cond_ok) begin
        mem_r <= 1'b0;
        mem_w <= 1'b0;
        wb_en <= 1'b0;
        b     <= 1'b0;
        s     <= 1'b0;
      end else begin
        mem_r <= d_mr;
        mem_w <= d_mw;
        wb_en <= d_wb;
        b     <= d_b;
        s     <= d_s;
      end
    end
  end

endmodule
